// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, frame geometry and parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    // Index of the last bit shifted in RECV (start bit is consumed in IDLE)
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 2);

    function automatic logic parity_odd(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO; DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push  = wr && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronize, deglitch, frame-decode and buffer scancodes.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic       CLK_VGA,
    input  logic       resetn,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    input  logic       rd_en,
    output logic [7:0] scancode,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err,
    input  logic       err_clr
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          fall_data;
    ps2_state_t    state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic [9:0]    shreg;
    logic          frame_ok;
    logic          timeout;
    logic          wr;
    logic          pop;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic [$clog2(FIFO_DEPTH):0] fill;

    always_ff @(posedge CLK_VGA) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], keyboard_clock};
            dat_sync <= {dat_sync[0], keyboard_data};
        end
    end

    // Level changes only after FILTER_LEN consecutive differing samples
    always_ff @(posedge CLK_VGA) begin
        if (!resetn) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FL_LAST) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge CLK_VGA) begin
        fall_data <= dat_sync[1];
    end

    assign frame_ok = shreg[9] && (parity_odd(shreg[8:0]) || !PARITY_EN);
    assign timeout  = (state == RECV) && !fall && (timer == TMO_LAST);
    assign wr       = (state == CHECK) && frame_ok;
    assign pop      = rd_en && valid;

    always_ff @(posedge CLK_VGA) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            timer     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !fall_data) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        timer   <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        timer   <= '0;
                        if (bit_cnt == LAST_BIT) state <= CHECK;
                    end else if (timeout) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CHECK:   state <= IDLE;
                default: state <= IDLE;
            endcase
            // A same-cycle set outranks err_clr
            if (timeout || ((state == CHECK) && !frame_ok)) frame_err <= 1'b1;
            else if (err_clr)                                frame_err <= 1'b0;
            if (wr && full && !pop) overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK_VGA) begin
        if ((state == RECV) && fall) shreg <= {fall_data, shreg[9:1]};
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (CLK_VGA),
        .resetn  (resetn),
        .wr      (wr),
        .wr_data (shreg[7:0]),
        .rd      (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fill)
    );

    assign valid    = (fill != '0);
    assign scancode = empty ? 8'h00 : head;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: bit-banged PS/2 frames, expected bytes queued and popped.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int HALF = 10;
    localparam int TMO  = 40000;

    logic       CLK_VGA        = 1'b0;
    logic       resetn         = 1'b0;
    logic       keyboard_clock = 1'b1;
    logic       keyboard_data  = 1'b1;
    logic       rd_en          = 1'b0;
    logic       err_clr        = 1'b0;
    logic [7:0] scancode;
    logic       valid;
    logic       overflow;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 CLK_VGA = ~CLK_VGA;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (8),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK_VGA        (CLK_VGA),
        .resetn         (resetn),
        .keyboard_clock (keyboard_clock),
        .keyboard_data  (keyboard_data),
        .rd_en          (rd_en),
        .scancode       (scancode),
        .valid          (valid),
        .overflow       (overflow),
        .frame_err      (frame_err),
        .err_clr        (err_clr)
    );

    task automatic clocks(input int n);
        repeat (n) @(posedge CLK_VGA);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] fr, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            keyboard_data = fr[i];
            clocks(HALF);
            keyboard_clock = 1'b0;
            if (i == glitch_bit) begin
                clocks(4);
                keyboard_clock = 1'b1;
                clocks(2);
                keyboard_clock = 1'b0;
                clocks(4);
            end else begin
                clocks(HALF);
            end
            keyboard_clock = 1'b1;
        end
        keyboard_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int glitch_bit);
        drive_bits(make_frame(b, bad_par, bad_stop), 11, glitch_bit);
        clocks(HALF + 5);
    endtask

    task automatic pop_dut(output logic [7:0] got, output bit ok);
        ok  = 1'b0;
        got = 8'h00;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (valid === 1'b1) ok = 1'b1;
            else clocks(1);
        end
        if (ok) begin
            got   = scancode;
            rd_en = 1'b1;
            clocks(1);
            rd_en = 1'b0;
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        clocks(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clocks(3);
        resetn = 1'b1;
        clocks(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode got %h want 00", scancode); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_basic();
        logic [7:0] got, exp;
        bit ok;
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        exp_q.push_back(8'h1C);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err got %b want 0", frame_err); end
        pop_dut(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_pop timeout want %h", exp); end
        else if (got !== exp) begin errors++; $display("FAIL basic_data got %h want %h", got, exp); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after_pop got %b want 0", valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        bit ok;
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b0, 1'b0, -1);
            if (b <= 8) exp_q.push_back(8'(b));
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovf_frame_err got %b want 0", frame_err); end
        for (int i = 0; i < 8; i++) begin
            pop_dut(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL ovf_pop%0d timeout want %h", i, exp); end
            else if (got !== exp) begin errors++; $display("FAIL ovf_data%0d got %h want %h", i, got, exp); end
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got valid %b want 0", valid); end
        clear_errs();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_parity();
        logic [7:0] got, exp;
        bit ok;
        send_frame(8'h1C, 1'b1, 1'b0, -1);
`ifdef PS2_PARITY_CHECK_EN
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", frame_err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL par_discard got valid %b want 0", valid); end
`else
        exp_q.push_back(8'h1C);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_ignored_err got %b want 0", frame_err); end
        pop_dut(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL par_pop timeout want %h", exp); end
        else if (got !== exp) begin errors++; $display("FAIL par_data got %h want %h", got, exp); end
`endif
        clear_errs();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b want 0", frame_err); end
        send_frame(8'h33, 1'b0, 1'b1, -1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL stop_err got %b want 1", frame_err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stop_discard got valid %b want 0", valid); end
        clear_errs();
    endtask

    task automatic test_timeout();
        logic [7:0] got, exp;
        bit ok;
        drive_bits(make_frame(8'hA5, 1'b0, 1'b0), 5, -1);
        clocks(TMO - 1000);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", frame_err); end
        clocks(1100);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", frame_err); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL tmo_state got %0d want %0d", dut.state, IDLE); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL tmo_discard got valid %b want 0", valid); end
        clear_errs();
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        exp_q.push_back(8'h5A);
        pop_dut(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_next_pop timeout want %h", exp); end
        else if (got !== exp) begin errors++; $display("FAIL tmo_next_data got %h want %h", got, exp); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tmo_next_err got %b want 0", frame_err); end
    endtask

    task automatic test_glitch();
        logic [7:0] got, exp;
        bit ok;
        send_frame(8'h6B, 1'b0, 1'b0, 3);
        exp_q.push_back(8'h6B);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_err got %b want 0", frame_err); end
        pop_dut(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL glitch_pop timeout want %h", exp); end
        else if (got !== exp) begin errors++; $display("FAIL glitch_data got %h want %h", got, exp); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_extra got valid %b want 0", valid); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got, exp;
        bit ok;
        drive_bits(make_frame(8'h77, 1'b0, 1'b0), 5, -1);
        resetn = 1'b0;
        clocks(2);
        resetn = 1'b1;
        clocks(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", dut.state, IDLE); end
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        exp_q.push_back(8'hF0);
        pop_dut(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_pop timeout want %h", exp); end
        else if (got !== exp) begin errors++; $display("FAIL rstmid_data got %h want %h", got, exp); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
